vx_branch_arb: RTL and testbench
================================

VX_BRANCH_ARB -- requirements
Module: VX_branch_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, number of branch-resolving requesters (1..8).
REQ-002 SHALL have parameter NUM_WARPS, default 4, number of warps tracked (power of two, 2..32).
REQ-003 SHALL derive NW_BITS = log2(NUM_WARPS) and RB = max(1, log2(NUM_REQS)).
REQ-004 SHALL use a single clock, and reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  async active-high reset.
REQ-007 req_valid  in  NUM_REQS  per-requester resolved-branch valid.
REQ-008 req_wid  in  NUM_REQS*NW_BITS  per-requester warp id, slice i = requester i.
REQ-009 req_taken  in  NUM_REQS  per-requester taken flag.
REQ-010 req_dest  in  NUM_REQS*32  per-requester branch target.
REQ-011 req_ready  out  NUM_REQS  one-hot grant, transfer when valid&ready.
REQ-012 issue_valid  in  1  a branch was issued this cycle.
REQ-013 issue_wid  in  NW_BITS  warp of issued branch.
REQ-014 branch_valid  out  1  branch_ctl master valid (no backpressure).
REQ-015 branch_wid  out  NW_BITS  branch_ctl master wid.
REQ-016 branch_taken  out  1  branch_ctl master taken.
REQ-017 branch_dest  out  32  branch_ctl master dest.
REQ-018 pending_mask  out  NUM_WARPS  bit w = warp w has an unresolved branch.
REQ-019 error  out  1  sticky protocol-violation flag.

Function
REQ-020 SHALL grant at most one requester per cycle, round-robin: first valid index at or after pointer ptr, wrapping modulo NUM_REQS.
REQ-021 req_ready SHALL be combinational from req_valid and ptr; req_ready[i]=1 only if req_valid[i]=1; all-zero when no valid.
REQ-022 On a grant to index g, ptr SHALL become (g+1) mod NUM_REQS at the next edge; with no grant ptr SHALL hold.
REQ-023 Output SHALL be registered: granted wid/taken/dest appear on branch_* with branch_valid=1 exactly one cycle after the grant cycle.
REQ-024 branch_valid SHALL be 0 in any cycle following a no-grant cycle; branch_wid/taken/dest SHALL hold last value when branch_valid=0.
REQ-025 Sustained throughput SHALL be one resolution per cycle; a requester held valid is granted within NUM_REQS cycles.
REQ-026 pending_mask[issue_wid] SHALL set at the edge after issue_valid=1.
REQ-027 pending_mask[w] SHALL clear at the edge ending a grant cycle for warp w, i.e. concurrent with branch_valid rising for w.
REQ-028 Simultaneous issue and grant for the same warp SHALL leave the bit set with no error (new branch supersedes).
REQ-029 error SHALL set, and remain set until reset, when issue_valid=1 for a warp already pending (and not cleared that cycle by grant), or a grant occurs for a warp not pending and not issued that cycle.
REQ-030 A protocol violation SHALL NOT suppress the grant or output; the resolution is still forwarded.
REQ-031 NUM_REQS=1 SHALL degenerate to req_ready=req_valid with ptr constant 0.

Reset
REQ-032 On reset assertion, branch_valid, branch_wid, branch_taken, branch_dest, pending_mask, error and ptr SHALL go to 0 immediately, independent of clk.
REQ-033 Reset mid-operation SHALL discard any in-flight registered output and all pending bits; req_ready SHALL be 0 while reset is high.
REQ-034 First grant after reset release SHALL start search at index 0.

Verification
REQ-035 Reset, issue wid=2, next cycle req0 valid wid=2 taken=1 dest=0x80000100 -> req_ready=01 that cycle; next cycle branch_valid=1 wid=2 taken=1 dest=0x80000100, pending_mask 0100->0000, error=0.
REQ-036 NUM_REQS=2, both requesters valid continuously for 4 cycles -> grants 0,1,0,1; branch_valid high 4 consecutive cycles starting one cycle later.
REQ-037 Pending warp 1, issue_valid wid=1 and grant wid=1 same cycle -> pending_mask[1] stays 1, error=0.
REQ-038 No pending bits, req1 valid wid=3 -> branch forwarded with wid=3, error=1 next cycle and stays 1 across later clean traffic.
REQ-039 Assert reset asynchronously in a cycle with branch_valid=1 and pending_mask=1111 -> all outputs 0 before next edge; after release req0 and req1 valid -> req0 granted first.

Source files
------------

// File: rtl/vx_branch_arb.sv
// Round-robin arbiter that funnels resolved branches from NUM_REQS units into one
// registered branch_ctl stream, tracking per-warp outstanding branches.
module vx_branch_arb #(
    parameter  int NUM_REQS  = 2,
    parameter  int NUM_WARPS = 4,
    localparam int NW_BITS   = $clog2(NUM_WARPS),
    localparam int RB        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         req_valid,
    input  logic [NUM_REQS*NW_BITS-1:0] req_wid,
    input  logic [NUM_REQS-1:0]         req_taken,
    input  logic [NUM_REQS*32-1:0]      req_dest,
    output logic [NUM_REQS-1:0]         req_ready,
    input  logic                        issue_valid,
    input  logic [NW_BITS-1:0]          issue_wid,
    output logic                        branch_valid,
    output logic [NW_BITS-1:0]          branch_wid,
    output logic                        branch_taken,
    output logic [31:0]                 branch_dest,
    output logic [NUM_WARPS-1:0]        pending_mask,
    output logic                        error
);

    logic [RB-1:0]         ptr_q, ptr_d;
    logic                  grant_vld;
    logic [RB-1:0]         grant_idx;
    logic [NUM_REQS-1:0]   grant_oh;
    logic [NW_BITS-1:0]    g_wid;
    logic                  g_taken;
    logic [31:0]           g_dest;

    logic                  bvalid_q;
    logic [NW_BITS-1:0]    bwid_q;
    logic                  btaken_q;
    logic [31:0]           bdest_q;
    logic [NUM_WARPS-1:0]  pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  viol_issue, viol_grant;

    // Search by distance from ptr so the first valid at or after ptr wins, wrapping.
    always_comb begin
        int p;
        p         = int'(ptr_q);
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        g_wid     = '0;
        g_taken   = 1'b0;
        g_dest    = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!grant_vld && req_valid[i] &&
                    (((i >= p) ? (i - p) : (i + NUM_REQS - p)) == k)) begin
                    grant_vld   = 1'b1;
                    grant_idx   = RB'(i);
                    grant_oh[i] = 1'b1;
                    g_wid       = req_wid[i*NW_BITS +: NW_BITS];
                    g_taken     = req_taken[i];
                    g_dest      = req_dest[i*32 +: 32];
                end
            end
        end
    end

    assign req_ready = reset ? '0 : grant_oh;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == RB'(NUM_REQS - 1)) ? '0 : grant_idx + RB'(1);
        end
    end

    // A same-cycle issue for the granted warp supersedes the clear.
    always_comb begin
        viol_issue = issue_valid && pend_q[issue_wid] && !(grant_vld && (g_wid == issue_wid));
        viol_grant = grant_vld && !pend_q[g_wid] && !(issue_valid && (issue_wid == g_wid));
        pend_d     = pend_q;
        if (grant_vld) begin
            pend_d[g_wid] = 1'b0;
        end
        if (issue_valid) begin
            pend_d[issue_wid] = 1'b1;
        end
        err_d = err_q | viol_issue | viol_grant;
    end

    // Grant stage -> registered branch_ctl output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            bvalid_q <= 1'b0;
            bwid_q   <= '0;
            btaken_q <= 1'b0;
            bdest_q  <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            bvalid_q <= grant_vld;
            if (grant_vld) begin
                bwid_q   <= g_wid;
                btaken_q <= g_taken;
                bdest_q  <= g_dest;
            end
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign branch_valid = bvalid_q;
    assign branch_wid   = bwid_q;
    assign branch_taken = btaken_q;
    assign branch_dest  = bdest_q;
    assign pending_mask = pend_q;
    assign error        = err_q;

endmodule

// File: tb/tb_vx_branch_arb.sv
// Bench for vx_branch_arb: per-cycle vector table with a scoreboard of expected
// branch_ctl outputs, plus a hand-written asynchronous-reset sequence.
module tb_vx_branch_arb;

    localparam int NR = 2;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [3:0]  req_wid;
    logic [1:0]  req_taken;
    logic [63:0] req_dest;
    logic [1:0]  req_ready;
    logic        issue_valid;
    logic [1:0]  issue_wid;
    logic        branch_valid;
    logic [1:0]  branch_wid;
    logic        branch_taken;
    logic [31:0] branch_dest;
    logic [3:0]  pending_mask;
    logic        error;

    always #5 clk = ~clk;

    vx_branch_arb #(.NUM_REQS(NR), .NUM_WARPS(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_wid     (req_wid),
        .req_taken   (req_taken),
        .req_dest    (req_dest),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_wid   (issue_wid),
        .branch_valid(branch_valid),
        .branch_wid  (branch_wid),
        .branch_taken(branch_taken),
        .branch_dest (branch_dest),
        .pending_mask(pending_mask),
        .error       (error)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  w0;
        logic [1:0]  w1;
        logic [1:0]  tk;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        iv;
        logic [1:0]  iw;
        logic [1:0]  rdy;
        logic [3:0]  pend;
        logic        err;
    } vec_t;

    typedef struct {
        logic        v;
        logic [1:0]  wid;
        logic        t;
        logic [31:0] dest;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] w0, input logic [1:0] w1,
                                input logic [1:0] tk, input logic [31:0] d0, input logic [31:0] d1,
                                input logic iv, input logic [1:0] iw, input logic [1:0] rdy,
                                input logic [3:0] pend, input logic err);
        vec_t v;
        v.rv = rv; v.w0 = w0; v.w1 = w1; v.tk = tk; v.d0 = d0; v.d1 = d1;
        v.iv = iv; v.iw = iw; v.rdy = rdy; v.pend = pend; v.err = err;
        return v;
    endfunction

    // Drive one cycle of stimulus, check the grant, then check the registered result.
    task automatic run_vec(input int n, input vec_t v);
        exp_t e;
        req_valid   = v.rv;
        req_wid     = {v.w1, v.w0};
        req_taken   = v.tk;
        req_dest    = {v.d1, v.d0};
        issue_valid = v.iv;
        issue_wid   = v.iw;
        #4;
        chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.rdy));
        if (v.rdy == 2'b01) begin
            e.v = 1'b1; e.wid = v.w0; e.t = v.tk[0]; e.dest = v.d0;
        end else if (v.rdy == 2'b10) begin
            e.v = 1'b1; e.wid = v.w1; e.t = v.tk[1]; e.dest = v.d1;
        end else begin
            e.v = 1'b0; e.wid = last.wid; e.t = last.t; e.dest = last.dest;
        end
        if (e.v) last = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", n), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d branch_valid", n), 32'(branch_valid), 32'(e.v));
            chk($sformatf("v%0d branch_wid", n), 32'(branch_wid), 32'(e.wid));
            chk($sformatf("v%0d branch_taken", n), 32'(branch_taken), 32'(e.t));
            chk($sformatf("v%0d branch_dest", n), branch_dest, e.dest);
        end
        chk($sformatf("v%0d pending_mask", n), 32'(pending_mask), 32'(v.pend));
        chk($sformatf("v%0d error", n), 32'(error), 32'(v.err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " branch_valid"}, 32'(branch_valid), 32'd0);
        chk({tag, " branch_wid"}, 32'(branch_wid), 32'd0);
        chk({tag, " branch_taken"}, 32'(branch_taken), 32'd0);
        chk({tag, " branch_dest"}, branch_dest, 32'd0);
        chk({tag, " pending_mask"}, 32'(pending_mask), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        last   = '{v: 1'b0, wid: 2'd0, t: 1'b0, dest: 32'h0};
        reset       = 1'b1;
        req_valid   = 2'b00;
        req_wid     = 4'h0;
        req_taken   = 2'b00;
        req_dest    = 64'h0;
        issue_valid = 1'b0;
        issue_wid   = 2'd0;

        // rv, w0, w1, tk, d0, d1, iv, iw, exp ready, exp pending, exp error
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd2, 2'b00, 4'h4, 1'b0));
        vecs.push_back(mk(2'b01, 2'd2, 2'd0, 2'b01, 32'h80000100, 32'h0,        1'b0, 2'd0, 2'b01, 4'h0, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd0, 2'b00, 4'h1, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd1, 2'b00, 4'h3, 1'b0));
        vecs.push_back(mk(2'b10, 2'd0, 2'd0, 2'b00, 32'h0,        32'h00001000, 1'b0, 2'd0, 2'b10, 4'h2, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd2, 2'b00, 4'h6, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd3, 2'b00, 4'hE, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd0, 2'b00, 4'hF, 1'b0));
        vecs.push_back(mk(2'b11, 2'd0, 2'd1, 2'b01, 32'h000000A0, 32'h000000A1, 1'b0, 2'd0, 2'b01, 4'hE, 1'b0));
        vecs.push_back(mk(2'b11, 2'd2, 2'd1, 2'b10, 32'h000000B0, 32'h000000B1, 1'b0, 2'd0, 2'b10, 4'hC, 1'b0));
        vecs.push_back(mk(2'b11, 2'd2, 2'd3, 2'b11, 32'h000000C0, 32'h000000C1, 1'b0, 2'd0, 2'b01, 4'h8, 1'b0));
        vecs.push_back(mk(2'b11, 2'd2, 2'd3, 2'b00, 32'h000000D0, 32'h000000D1, 1'b0, 2'd0, 2'b10, 4'h0, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd1, 2'b00, 4'h2, 1'b0));
        vecs.push_back(mk(2'b01, 2'd1, 2'd0, 2'b01, 32'h000000E0, 32'h0,        1'b1, 2'd1, 2'b01, 4'h2, 1'b0));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b0, 2'd0, 2'b00, 4'h2, 1'b0));
        vecs.push_back(mk(2'b01, 2'd1, 2'd0, 2'b00, 32'h000000F0, 32'h0,        1'b0, 2'd0, 2'b01, 4'h0, 1'b0));
        vecs.push_back(mk(2'b10, 2'd0, 2'd3, 2'b10, 32'h0,        32'hDEAD0000, 1'b0, 2'd0, 2'b10, 4'h0, 1'b1));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b1, 2'd0, 2'b00, 4'h1, 1'b1));
        vecs.push_back(mk(2'b01, 2'd0, 2'd0, 2'b01, 32'h12345678, 32'h0,        1'b0, 2'd0, 2'b01, 4'h0, 1'b1));
        vecs.push_back(mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0,        32'h0,        1'b0, 2'd0, 2'b00, 4'h0, 1'b1));

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        req_valid = 2'b11;
        #1;
        chk("reset req_ready_both_valid", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        reset     = 1'b0;

        foreach (vecs[n]) run_vec(n, vecs[n]);

        // Fill all pending bits, then land a grant+reissue so branch_valid=1 with mask 1111.
        run_vec(100, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd1, 2'b00, 4'h2, 1'b1));
        run_vec(101, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd2, 2'b00, 4'h6, 1'b1));
        run_vec(102, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd3, 2'b00, 4'hE, 1'b1));
        run_vec(103, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 2'b00, 4'hF, 1'b1));
        run_vec(104, mk(2'b01, 2'd0, 2'd0, 2'b01, 32'h55AA55AA, 32'h0, 1'b1, 2'd0, 2'b01, 4'hF, 1'b1));

        // Asynchronous reset mid-cycle while output is valid and every warp is pending.
        req_valid   = 2'b11;
        issue_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        last = '{v: 1'b0, wid: 2'd0, t: 1'b0, dest: 32'h0};
        @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        reset = 1'b0;

        // After release the search restarts at requester 0.
        run_vec(200, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd1, 2'b00, 4'h2, 1'b0));
        run_vec(201, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd2, 2'b00, 4'h6, 1'b0));
        run_vec(202, mk(2'b11, 2'd1, 2'd2, 2'b10, 32'h00000111, 32'h00000222, 1'b0, 2'd0, 2'b01, 4'h4, 1'b0));
        run_vec(203, mk(2'b10, 2'd0, 2'd2, 2'b10, 32'h0, 32'h00000222, 1'b0, 2'd0, 2'b10, 4'h0, 1'b0));
        // Re-issuing a warp that is still pending is a protocol violation.
        run_vec(204, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd3, 2'b00, 4'h8, 1'b0));
        run_vec(205, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b1, 2'd3, 2'b00, 4'h8, 1'b1));
        run_vec(206, mk(2'b00, 2'd0, 2'd0, 2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 2'b00, 4'h8, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
